// File: rtl/row_buffer_pkg.sv
// Shared types and elaboration-time helpers for the inter-layer row buffer read side.
package row_buffer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } rbr_state_t;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int hint_len(input int ram_count, input int pixels_per_word);
    return ram_count * pixels_per_word;
  endfunction

  // Number of K-row windows that fit in in_rows at stride s: floor((in_rows-k)/s)+1.
  function automatic int out_rows(input int in_rows, input int k, input int s);
    return ceil_div(in_rows - k + 1, s);
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/row_buffer_reader_if.sv
// Valid/ready row stream from the buffer reader to row2pe: one full padded row per beat.
interface row_buffer_reader_if #(
  parameter int DATA_W = 224,
  parameter int KW     = 2
);
  logic [DATA_W-1:0] data;
  logic [KW-1:0]     k;
  logic              valid;
  logic              ready;
  logic              last;

  modport master (output data, k, valid, last, input ready);
  modport slave  (input data, k, valid, last, output ready);
endinterface

// File: rtl/row_buffer_rd_fifo.sv
// Two-entry fall-through FIFO: an entry pushed into an empty FIFO is visible (and poppable) the same cycle.
module row_buffer_rd_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_rdata,
  output logic [1:0]       o_count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;

  logic w_empty;
  logic w_store;
  logic w_take;

  assign w_empty = (r_count == 2'd0);
  assign w_store = i_push && !(i_pop && w_empty);
  assign w_take  = i_pop && !w_empty;

  assign o_valid = !w_empty || i_push;
  assign o_rdata = !w_empty ? r_mem[r_rd_ptr] : (i_push ? i_wdata : '0);
  assign o_count = r_count;

  // NOTE: storage has no reset; occupancy alone says which entries are meaningful.
  always_ff @(posedge clk) begin
    if (w_store) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_store) r_wr_ptr <= ~r_wr_ptr;
      if (w_take)  r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + 2'(w_store) - 2'(w_take);
    end
  end

endmodule

// File: rtl/row_buffer_reader.sv
// Reads buffered rows in K-row sliding-window order (stride S) and streams them to row2pe.
module row_buffer_reader
  import row_buffer_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter int LAST_Iw          = 7,
  parameter int BUFFER_RAM_COUNT = 4,
  parameter int IN_ROWS          = 25,
  parameter int K                = 3,
  parameter int S                = 1,
  parameter int ADDR_WIDTH       = 32,
  parameter int ROW_WIDTH        = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          buffer_reader_en,
  input  logic [ROW_WIDTH-1:0]          rows_avail,
  output logic                          buffer_reader_ram_rden    [BUFFER_RAM_COUNT],
  output logic [ADDR_WIDTH-1:0]         buffer_reader_ram_rd_addr [BUFFER_RAM_COUNT],
  input  logic [LAST_Iw*DATA_WIDTH-1:0] buffer_reader_ram_rd_data [BUFFER_RAM_COUNT],
  row_buffer_reader_if.master           row2pe,
  output logic                          buffer_reader_busy,
  output logic                          buffer_reader_done
);

  localparam int LW       = LAST_Iw * DATA_WIDTH;
  localparam int HINT_W   = hint_len(BUFFER_RAM_COUNT, LAST_Iw) * DATA_WIDTH;
  localparam int KW       = idx_width(K);
  localparam int OUT_ROWS = out_rows(IN_ROWS, K, S);
  localparam int BEATS    = OUT_ROWS * K;
  localparam int CW       = $clog2(BEATS + 1);
  localparam int EW       = HINT_W + KW + 1;

  if (IN_ROWS >= (1 << ROW_WIDTH)) begin : g_bad_row_width
    $error("row_buffer_reader: IN_ROWS does not fit in ROW_WIDTH");
  end
  if (K > IN_ROWS || S < 1) begin : g_bad_window
    $error("row_buffer_reader: window does not fit the stored rows");
  end

  rbr_state_t          r_state;
  logic [ROW_WIDTH-1:0] r_base;
  logic [KW-1:0]        r_k;
  logic [CW-1:0]        r_issued;
  logic                 r_rden;
  logic [ROW_WIDTH-1:0] r_addr;
  logic [KW-1:0]        r_k1;
  logic                 r_last1;
  logic                 r_rd_vld;
  logic [KW-1:0]        r_k2;
  logic                 r_last2;
  logic                 r_busy;
  logic                 r_done;

  logic [ROW_WIDTH-1:0] w_row;
  logic [HINT_W-1:0]    w_row_data;
  logic [EW-1:0]        w_fifo_rdata;
  logic                 w_fifo_valid;
  logic [1:0]           w_fifo_count;
  logic                 w_pop;
  logic [2:0]           w_used;
  logic                 w_issue;
  logic                 w_issue_last;

  for (genvar i = 0; i < BUFFER_RAM_COUNT; i++) begin : g_ram
    assign buffer_reader_ram_rden[i]    = r_rden;
    assign buffer_reader_ram_rd_addr[i] = ADDR_WIDTH'(r_addr);
    assign w_row_data[i*LW +: LW]       = buffer_reader_ram_rd_data[i];
  end

  assign w_row = r_base + ROW_WIDTH'(r_k);
  assign w_pop = w_fifo_valid && row2pe.ready;

  // Rows held in the FIFO plus the two read-pipeline stages never exceed the FIFO depth.
  assign w_used       = 3'(w_fifo_count) + 3'(r_rden) + 3'(r_rd_vld) - 3'(w_pop);
  assign w_issue      = (r_state == RUN) && (w_row < rows_avail) && (w_used < 3'd2);
  assign w_issue_last = w_issue && (r_issued == CW'(BEATS - 1));

  row_buffer_rd_fifo #(
    .WIDTH(EW)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_push (r_rd_vld),
    .i_wdata({w_row_data, r_k2, r_last2}),
    .i_pop  (w_pop),
    .o_valid(w_fifo_valid),
    .o_rdata(w_fifo_rdata),
    .o_count(w_fifo_count)
  );

  assign row2pe.valid                           = w_fifo_valid;
  assign {row2pe.data, row2pe.k, row2pe.last}   = w_fifo_rdata;
  assign buffer_reader_busy                     = r_busy;
  assign buffer_reader_done                     = r_done;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_base   <= '0;
      r_k      <= '0;
      r_issued <= '0;
      r_rden   <= 1'b0;
      r_addr   <= '0;
      r_k1     <= '0;
      r_last1  <= 1'b0;
      r_rd_vld <= 1'b0;
      r_k2     <= '0;
      r_last2  <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_rden   <= w_issue;
      r_rd_vld <= r_rden;
      r_k2     <= r_k1;
      r_last2  <= r_last1;
      r_done   <= 1'b0;

      if (w_issue) begin
        r_addr   <= w_row;
        r_k1     <= r_k;
        r_last1  <= w_issue_last;
        r_issued <= r_issued + 1'b1;
        if (r_k == KW'(K - 1)) begin
          r_k    <= '0;
          r_base <= r_base + ROW_WIDTH'(S);
        end else begin
          r_k <= r_k + 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          if (buffer_reader_en) begin
            r_state  <= RUN;
            r_busy   <= 1'b1;
            r_base   <= '0;
            r_k      <= '0;
            r_issued <= '0;
          end
        end
        RUN: begin
          if (w_issue_last) r_state <= DRAIN;
        end
        DRAIN: begin
          // Popping the beat tagged last empties both the FIFO and the read pipeline.
          if (w_pop && row2pe.last) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_buffer_reader.sv
// Directed bench: default build (S=1) and a stride-2 build share clock/reset, each with its own RAM model.
module tb_row_buffer_reader;

  localparam int DW      = 8;
  localparam int IW      = 7;
  localparam int RC      = 4;
  localparam int IN_ROWS = 25;
  localparam int K       = 3;
  localparam int AW      = 32;
  localparam int RW      = 10;
  localparam int HINT    = RC * IW;
  localparam int DATA_W  = HINT * DW;
  localparam int KW      = 2;
  localparam int LW      = IW * DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          en0, en1;
  logic [RW-1:0] avail0, avail1;
  logic          rdy0, rdy1;
  logic          rden0 [RC];
  logic          rden1 [RC];
  logic [AW-1:0] addr0 [RC];
  logic [AW-1:0] addr1 [RC];
  logic [LW-1:0] rdat0 [RC];
  logic [LW-1:0] rdat1 [RC];
  logic          busy0, busy1, done0, done1;

  row_buffer_reader_if #(.DATA_W(DATA_W), .KW(KW)) if0 ();
  row_buffer_reader_if #(.DATA_W(DATA_W), .KW(KW)) if1 ();
  assign if0.ready = rdy0;
  assign if1.ready = rdy1;

  row_buffer_reader dut0 (
    .clk                      (clk),
    .rst                      (rst),
    .buffer_reader_en         (en0),
    .rows_avail               (avail0),
    .buffer_reader_ram_rden   (rden0),
    .buffer_reader_ram_rd_addr(addr0),
    .buffer_reader_ram_rd_data(rdat0),
    .row2pe                   (if0),
    .buffer_reader_busy       (busy0),
    .buffer_reader_done       (done0)
  );

  row_buffer_reader #(.S(2)) dut1 (
    .clk                      (clk),
    .rst                      (rst),
    .buffer_reader_en         (en1),
    .rows_avail               (avail1),
    .buffer_reader_ram_rden   (rden1),
    .buffer_reader_ram_rd_addr(addr1),
    .buffer_reader_ram_rd_data(rdat1),
    .row2pe                   (if1),
    .buffer_reader_busy       (busy1),
    .buffer_reader_done       (done1)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int beat      [2];
  int n_rd      [2];
  int n_acc     [2];
  int first_acc [2];
  int last_acc  [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Pixel value encodes (ram, row, lane) so swapped RAMs, rows or lanes all show up.
  function automatic logic [DW-1:0] lane_val(input int ram, input int row, input int j);
    return DW'(row * 37 + (ram * IW + j) * 3 + ram);
  endfunction

  function automatic logic [LW-1:0] ram_word(input int ram, input int row);
    logic [LW-1:0] w;
    w = '0;
    for (int j = 0; j < IW; j++) w[j*DW +: DW] = lane_val(ram, row, j);
    return w;
  endfunction

  function automatic logic [DATA_W-1:0] exp_data(input int row);
    logic [DATA_W-1:0] d;
    d = '0;
    for (int i = 0; i < RC; i++)
      for (int j = 0; j < IW; j++) d[(i*IW + j)*DW +: DW] = lane_val(i, row, j);
    return d;
  endfunction

  function automatic int exp_row(input int b, input int s);
    return (b / K) * s + (b % K);
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < RC; i++) begin
      if (rden0[i]) rdat0[i] <= ram_word(i, int'(addr0[i]));
      if (rden1[i]) rdat1[i] <= ram_word(i, int'(addr1[i]));
    end
  end

  task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input int s, input int beats, input logic v, input logic rdy,
                     input logic [DATA_W-1:0] data, input logic [KW-1:0] kk, input logic lst,
                     input logic rd, input logic [AW-1:0] ad, input logic same, input logic [RW-1:0] av);
    check("ram_sync", same, 1'b1);
    if (rd) begin
      check("rd_addr", ad, exp_row(n_rd[d], s));
      check("rd_avail", ad < AW'(av), 1'b1);
      n_rd[d]++;
      check("credit", (n_rd[d] - n_acc[d]) <= 2, 1'b1);
    end
    if (v) begin
      check("beat_in_range", beat[d] < beats, 1'b1);
      check("data", data, exp_data(exp_row(beat[d], s)));
      check("k", kk, beat[d] % K);
      check("last", lst, beat[d] == beats - 1);
      if (rdy) begin
        if (beat[d] == 0) first_acc[d] = cyc;
        last_acc[d] = cyc;
        beat[d]++;
        n_acc[d]++;
      end
    end
  endtask

  always @(negedge clk) begin
    logic same0, same1;
    same0 = 1'b1;
    same1 = 1'b1;
    for (int i = 0; i < RC; i++) begin
      if (rden0[i] !== rden0[0] || addr0[i] !== addr0[0]) same0 = 1'b0;
      if (rden1[i] !== rden1[0] || addr1[i] !== addr1[0]) same1 = 1'b0;
    end
    if (rst === 1'b0) begin
      mon(0, 1, 69, if0.valid, if0.ready, if0.data, if0.k, if0.last, rden0[0], addr0[0], same0, avail0);
      mon(1, 2, 36, if1.valid, if1.ready, if1.data, if1.k, if1.last, rden1[0], addr1[0], same1, avail1);
    end
  end

  task automatic start(input int d);
    beat[d] = 0; n_rd[d] = 0; n_acc[d] = 0; first_acc[d] = 0; last_acc[d] = 0;
    @(posedge clk); #1;
    if (d == 0) en0 = 1'b1; else en1 = 1'b1;
    @(posedge clk); #1;
    en0 = 1'b0;
    en1 = 1'b0;
  endtask

  // Returns at the negedge where done is seen, or after the budget with a failed check.
  task automatic wait_done(input int d, input int budget);
    int n;
    for (n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((d == 0) ? done0 : done1) break;
    end
    check("done_seen", n < budget, 1'b1);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_rden"}, rden0[0], 1'b0);
    check({tag, "_valid"}, if0.valid, 1'b0);
    check({tag, "_data"}, if0.data, '0);
    check({tag, "_k"}, if0.k, '0);
    check({tag, "_last"}, if0.last, 1'b0);
    check({tag, "_busy"}, busy0, 1'b0);
    check({tag, "_done"}, done0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
    avail0 = '0; avail1 = '0; rdy0 = 1'b0; rdy1 = 1'b0;
    for (int d = 0; d < 2; d++) begin
      beat[d] = 0; n_rd[d] = 0; n_acc[d] = 0; first_acc[d] = 0; last_acc[d] = 0;
    end
    #1;
    check_quiet("reset");
    check("reset_valid1", if1.valid, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("idle");

    // 1: all rows available, ready held high.
    avail0 = 10'd25; rdy0 = 1'b1;
    start(0);
    lat = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (if0.valid) break;
      lat++;
    end
    check("first_valid_latency", lat, 2);
    check("busy_running", busy0, 1'b1);
    wait_done(0, 300);
    check("t1_beats", beat[0], 69);
    check("t1_reads", n_rd[0], 69);
    check("t1_done_after_last", cyc - last_acc[0], 1);
    check("t1_full_rate", last_acc[0] - first_acc[0], 68);
    check("t1_busy_at_done", busy0, 1'b0);
    @(negedge clk);
    check("t1_done_pulse", done0, 1'b0);

    // 2: only rows 0..2 written, rest arrives later; windows 0 and the first two reads of window 1 fit.
    avail0 = 10'd3;
    start(0);
    repeat (20) @(posedge clk);
    #2;
    check("t2_stall_reads", n_rd[0], 5);
    check("t2_stall_beats", beat[0], 5);
    check("t2_stall_rden", rden0[0], 1'b0);
    check("t2_stall_busy", busy0, 1'b1);
    avail0 = 10'd25;
    wait_done(0, 300);
    check("t2_beats", beat[0], 69);
    check("t2_reads", n_rd[0], 69);

    // 3: ready toggled randomly.
    rdy0 = 1'b0;
    start(0);
    for (int n = 0; n < 1000; n++) begin
      @(posedge clk); #1;
      if (done0) break;
      rdy0 = 1'($urandom_range(0, 1));
    end
    check("t3_done_seen", done0, 1'b1);
    check("t3_beats", beat[0], 69);
    rdy0 = 1'b1;

    // 5: reset in the middle of a pass, then a clean restart.
    start(0);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #2;
      if (beat[0] >= 30) break;
    end
    check("t5_reached_30", beat[0] >= 30, 1'b1);
    rst = 1'b1;
    #1;
    check_quiet("midreset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_quiet("after_reset");
    start(0);
    wait_done(0, 300);
    check("t5_beats", beat[0], 69);
    check("t5_reads", n_rd[0], 69);

    // 6: stride-2 build, 12 windows.
    avail1 = 10'd25; rdy1 = 1'b1;
    start(1);
    wait_done(1, 300);
    check("t6_beats", beat[1], 36);
    check("t6_reads", n_rd[1], 36);
    check("t6_full_rate", last_acc[1] - first_acc[1], 35);
    check("t6_done_after_last", cyc - last_acc[1], 1);

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
